// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {D_ZERO, D_P1, D_P2, D_M1, D_M2} digit_t;

    // Internal width: smallest even number >= width+1, leaving room for the
    // extension bit that lets unsigned operands ride a signed datapath.
    function automatic int iw_of(input int width);
        return (width % 2 == 0) ? width + 2 : width + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps {q[1], q[0], q[-1]} to one signed digit.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] i_bits,
    output digit_t     o_digit
);

    // Standard radix-4 recoding table.
    always_comb begin
        o_digit = D_ZERO;
        case (i_bits)
            3'b001, 3'b010: o_digit = D_P1;
            3'b011:         o_digit = D_P2;
            3'b100:         o_digit = D_M2;
            3'b101, 3'b110: o_digit = D_M1;
            default:        o_digit = D_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier with start/busy/done handshake.
// Retires two multiplier bits per clock; signed or unsigned per operation.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int IW   = iw_of(WIDTH);
    localparam int ITER = IW / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t                   r_state;
    logic signed [IW+1:0]     r_acc;
    logic [IW-1:0]            r_q;
    logic [IW-1:0]            r_m;
    logic                     r_qm1;
    logic [CW-1:0]            r_cnt;
    logic                     r_busy;
    logic                     r_done;
    logic [2*WIDTH-1:0]       r_prod;

    digit_t                   w_digit;
    logic [IW-1:0]            w_a_ext;
    logic [IW-1:0]            w_b_ext;
    logic signed [IW+1:0]     w_mext;
    logic signed [IW+1:0]     w_opnd;
    logic signed [IW+1:0]     w_addend;
    logic                     w_sub;
    logic signed [IW+1:0]     w_sum;
    logic signed [2*IW+2:0]   w_shift;

    // Operand extension to IW bits; the top bit is the sign in signed mode
    // and a forced zero in unsigned mode.
    assign w_a_ext = {{(IW-WIDTH){signed_mode & a[WIDTH-1]}}, a};
    assign w_b_ext = {{(IW-WIDTH){signed_mode & b[WIDTH-1]}}, b};

    booth_r4_enc u_enc (
        .i_bits  ({r_q[1:0], r_qm1}),
        .o_digit (w_digit)
    );

    // Select +/-M or +/-2M and feed a single adder/subtractor at IW+2 bits
    // so that -2M of the most-negative multiplicand still fits.
    always_comb begin
        w_mext   = {{2{r_m[IW-1]}}, r_m};
        w_opnd   = '0;
        w_sub    = 1'b0;
        case (w_digit)
            D_P1: w_opnd = w_mext;
            D_P2: w_opnd = w_mext <<< 1;
            D_M1: begin w_opnd = w_mext;       w_sub = 1'b1; end
            D_M2: begin w_opnd = w_mext <<< 1; w_sub = 1'b1; end
            default: w_opnd = '0;
        endcase
        w_addend = w_sub ? ~w_opnd : w_opnd;
        w_sum    = r_acc + w_addend + (IW+2)'(w_sub);
        w_shift  = $signed({w_sum, r_q, r_qm1}) >>> 2;
    end

    // Control FSM plus datapath registers; outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_prod  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= w_a_ext;
                        r_q     <= w_b_ext;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_shift[2*IW+2 -: IW+2];
                    r_q   <= w_shift[IW:1];
                    r_qm1 <= w_shift[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        // Capture the product from the final shift so it is
                        // valid in the same cycle the done pulse appears.
                        r_prod  <= w_shift[2*WIDTH:1];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign prod = r_prod;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Testbench for booth_mul_seq: directed handshake/corner cases at WIDTH=8
// and a randomized back-to-back sweep at WIDTH 2, 5, 8 and 16.
module tb_booth_mul_seq;

    localparam int NOPS = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  st  = '0;
    logic [3:0]  sm  = '0;
    logic [3:0]  by;
    logic [3:0]  dn;
    logic [15:0] av [4];
    logic [15:0] bv [4];
    logic [3:0]  p_w2;
    logic [9:0]  p_w5;
    logic [15:0] p_w8;
    logic [31:0] p_w16;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_mul_seq #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm[0]),
        .a(av[0][1:0]), .b(bv[0][1:0]), .busy(by[0]), .done(dn[0]), .prod(p_w2));
    booth_mul_seq #(.WIDTH(5)) u_w5 (
        .clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm[1]),
        .a(av[1][4:0]), .b(bv[1][4:0]), .busy(by[1]), .done(dn[1]), .prod(p_w5));
    booth_mul_seq #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(st[2]), .signed_mode(sm[2]),
        .a(av[2][7:0]), .b(bv[2][7:0]), .busy(by[2]), .done(dn[2]), .prod(p_w8));
    booth_mul_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start(st[3]), .signed_mode(sm[3]),
        .a(av[3]), .b(bv[3]), .busy(by[3]), .done(dn[3]), .prod(p_w16));

    function automatic logic [31:0] prod_of(input int k);
        case (k)
            0:       return {28'b0, p_w2};
            1:       return {22'b0, p_w5};
            2:       return {16'b0, p_w8};
            default: return p_w16;
        endcase
    endfunction

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input logic s);
        longint m, xv, yv, p;
        m  = (longint'(1) << w) - 1;
        xv = longint'(x) & m;
        yv = longint'(y) & m;
        if (s && xv[w-1]) xv = xv - (longint'(1) << w);
        if (s && yv[w-1]) yv = yv - (longint'(1) << w);
        p = xv * yv;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge on the WIDTH=8 instance.
    task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic s);
        av[2] = {8'h00, x};
        bv[2] = {8'h00, y};
        sm[2] = s;
        st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
    endtask

    // Called in the cycle after the accepting edge; expects done 6 cycles
    // after that edge, with the given product, then a single-cycle pulse.
    task automatic wait8(input string tag, input logic [15:0] exp);
        int lat = 1;
        bit seen = 1'b0;
        bit overlap = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            lat++;
            if (by[2] && dn[2]) overlap = 1'b1;
            if (dn[2]) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd6);
        check({tag, "_prod"}, {16'b0, p_w8}, {16'b0, exp});
        check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        tick();
        check({tag, "_done_pulse_end"}, 32'(dn[2]), 32'd0);
    endtask

    initial begin
        int pulses;
        for (int k = 0; k < 4; k++) begin
            av[k] = '0;
            bv[k] = '0;
        end

        // Reset held two edges; start raised on the last reset edge is dropped.
        tick();
        check("rst1_busy", 32'(by[2]), 32'd0);
        check("rst1_done", 32'(dn[2]), 32'd0);
        check("rst1_prod", {16'b0, p_w8}, 32'd0);
        av[2] = 16'h0003;
        bv[2] = 16'h0005;
        sm[2] = 1'b1;
        st[2] = 1'b1;
        tick();
        check("rst2_busy", 32'(by[2]), 32'd0);
        check("rst2_done", 32'(dn[2]), 32'd0);
        check("rst2_prod", {16'b0, p_w8}, 32'd0);
        rst = 1'b0;
        tick();
        st[2] = 1'b0;
        check("post_rst_accept", 32'(by[2]), 32'd1);
        wait8("post_rst", 16'h000F);

        // Signed corners.
        go8(8'h80, 8'h80, 1'b1);
        check("s_minsq_busy", 32'(by[2]), 32'd1);
        wait8("s_minsq", 16'h4000);
        go8(8'h7F, 8'hFF, 1'b1);
        wait8("s_7f_m1", 16'hFF81);

        // Same bits, unsigned vs signed.
        go8(8'hFF, 8'hFF, 1'b0);
        wait8("u_ff_ff", 16'hFE01);
        go8(8'hFF, 8'hFF, 1'b1);
        wait8("s_ff_ff", 16'h0001);

        // Starts during RUN are ignored.
        go8(8'h12, 8'h34, 1'b0);
        tick();
        av[2] = 16'h0055; bv[2] = 16'h0066; sm[2] = 1'b1; st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
        tick();
        av[2] = 16'h0077; bv[2] = 16'h0011; st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (dn[2]) begin
                pulses++;
                check("ignore_prod", {16'b0, p_w8}, 32'h0000_03A8);
            end
            tick();
        end
        check("ignore_pulses", 32'(pulses), 32'd1);
        check("ignore_prod_held", {16'b0, p_w8}, 32'h0000_03A8);
        check("ignore_idle_busy", 32'(by[2]), 32'd0);

        // Reset in the third RUN cycle aborts the operation.
        go8(8'h0A, 8'h0B, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(by[2]), 32'd0);
        check("abort_done", 32'(dn[2]), 32'd0);
        check("abort_prod", {16'b0, p_w8}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dn[2]) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        go8(8'hF6, 8'h07, 1'b1);
        wait8("after_abort", 16'hFFBA);

        // Randomized back-to-back sweep per width; start is held high so each
        // new operation is accepted in the IDLE cycle right after DONE.
        for (int k = 0; k < 4; k++) begin
            int w, it, lastdone;
            logic [31:0] exp;
            bit ok;
            w  = (k == 0) ? 2 : (k == 1) ? 5 : (k == 2) ? 8 : 16;
            it = (((w + 1) % 2 == 0) ? (w + 1) : (w + 2)) / 2;
            lastdone = -1;
            av[k] = 16'($urandom);
            bv[k] = 16'($urandom);
            sm[k] = 1'($urandom_range(0, 1));
            st[k] = 1'b1;
            for (int n = 0; n < NOPS; n++) begin
                exp = ref_mul(w, av[k], bv[k], sm[k]);
                ok = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    tick();
                    if (by[k]) begin
                        ok = 1'b1;
                        break;
                    end
                end
                check($sformatf("sweep_w%0d_accept", w), 32'(ok), 32'd1);
                av[k] = 16'($urandom);
                bv[k] = 16'($urandom);
                sm[k] = 1'($urandom_range(0, 1));
                ok = 1'b0;
                for (int c = 0; c < 40; c++) begin
                    tick();
                    if (dn[k]) begin
                        ok = 1'b1;
                        break;
                    end
                end
                check($sformatf("sweep_w%0d_done", w), 32'(ok), 32'd1);
                check($sformatf("sweep_w%0d_prod", w), prod_of(k), exp);
                if (lastdone >= 0)
                    check($sformatf("sweep_w%0d_spacing", w), 32'(cyc - lastdone), 32'(it + 2));
                lastdone = cyc;
            end
            st[k] = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
